// File: rtl/iir_out_buffer_pkg.sv
// Shared constants and sample type for the IIR filter output path.
// The filter, the stimulus and the sink all import this package so that they
// agree on the sample width and the default buffer depth.
package iir_out_buffer_pkg;

  localparam int NB_DEF    = 12;  // filter data width
  localparam int DEPTH_DEF = 8;   // output buffer slots (power of 2)

  typedef logic signed [NB_DEF-1:0] sample_t;

endpackage : iir_out_buffer_pkg

// File: rtl/iir_buf_mem.sv
// Sample storage for the IIR output buffer: DEPTH x NB register array.
// Latency: write lands on the rising edge; read is combinational from raddr_i.
// Backpressure: none; the owner decides when a write is legal.
// Ports: CLK/RST_n clock and async active-low clear, we_i/waddr_i/wdata_i
//        write port, raddr_i/rdata_o combinational read port.
module iir_buf_mem
  import iir_out_buffer_pkg::*;
#(
  parameter int NB    = NB_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RST_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [NB-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [NB-1:0] rdata_o
);

  logic [NB-1:0] mem_q [DEPTH];

  // Reset clears every slot so the head reads as zero after reset.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : iir_buf_mem

// File: rtl/iir_out_buffer.sv
// Elastic buffer between the IIR filter output and its consumer.
// Latency: a sample pushed on edge k is visible on DOUT/VOUT after edge k.
// Backpressure: RD stalls the consumer side; the filter cannot be stalled, so
//   a sample arriving while full with no pop is dropped and counted.
// Ports: DIN/VIN filter side, DOUT/VOUT/RD consumer handshake, COUNT/FULL
//        occupancy, OVF/DROPS overflow status, CLR_OVF clears the status.
module iir_out_buffer
  import iir_out_buffer_pkg::*;
#(
  parameter int NB    = NB_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RST_n,
  input  logic [NB-1:0] DIN,
  input  logic          VIN,
  output logic [NB-1:0] DOUT,
  output logic          VOUT,
  input  logic          RD,
  output logic [AW:0]   COUNT,
  output logic          FULL,
  output logic          OVF,
  output logic [7:0]    DROPS,
  input  logic          CLR_OVF
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          vout_q, vout_d;
  logic          full_q, full_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    drops_q, drops_d;

  logic pop;
  logic push;
  logic drop;

  // A pop frees the slot the push needs, so a full buffer still accepts
  // when the consumer takes a sample in the same cycle.
  assign pop  = vout_q & RD;
  assign push = VIN & (~full_q | pop);
  assign drop = VIN & full_q & ~pop;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    drops_d = drops_q;

    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // A drop in the same cycle as a clear wins: the new drop is the first
    // one counted after the clear.
    if (drop) begin
      ovf_d = 1'b1;
      if (CLR_OVF)                drops_d = 8'd1;
      else if (drops_q != 8'hFF)  drops_d = drops_q + 8'd1;
    end else if (CLR_OVF) begin
      ovf_d   = 1'b0;
      drops_d = 8'd0;
    end

    vout_d = (count_d != '0);
    full_d = (count_d == FULL_CNT);
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      vout_q  <= 1'b0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      drops_q <= 8'd0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      vout_q  <= vout_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
      drops_q <= drops_d;
    end
  end

  iir_buf_mem #(
    .NB    (NB),
    .DEPTH (DEPTH)
  ) u_mem (
    .CLK     (CLK),
    .RST_n   (RST_n),
    .we_i    (push),
    .waddr_i (wptr_q),
    .wdata_i (DIN),
    .raddr_i (rptr_q),
    .rdata_o (DOUT)
  );

  assign VOUT  = vout_q;
  assign FULL  = full_q;
  assign COUNT = count_q;
  assign OVF   = ovf_q;
  assign DROPS = drops_q;

endmodule : iir_out_buffer

// File: tb/tb_iir_out_buffer.sv
// Scoreboard bench for iir_out_buffer: stimulus pushes expected samples into
// a queue, a monitor pops and compares whenever the DUT completes a handshake.
module tb_iir_out_buffer;
  import iir_out_buffer_pkg::*;

  localparam int NB = NB_DEF;
  localparam int DEPTH = DEPTH_DEF;

  logic          CLK = 1'b0;
  logic          RST_n = 1'b0;
  logic [NB-1:0] DIN = '0;
  logic          VIN = 1'b0;
  logic [NB-1:0] DOUT;
  logic          VOUT;
  logic          RD = 1'b0;
  logic [3:0]    COUNT;
  logic          FULL;
  logic          OVF;
  logic [7:0]    DROPS;
  logic          CLR_OVF = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  // bench-side expectation state
  logic [NB-1:0] exp_q[$];
  int            m_count = 0;
  bit            m_ovf = 0;
  int            m_drops = 0;

  iir_out_buffer #(.NB(NB), .DEPTH(DEPTH)) dut (
    .CLK     (CLK),
    .RST_n   (RST_n),
    .DIN     (DIN),
    .VIN     (VIN),
    .DOUT    (DOUT),
    .VOUT    (VOUT),
    .RD      (RD),
    .COUNT   (COUNT),
    .FULL    (FULL),
    .OVF     (OVF),
    .DROPS   (DROPS),
    .CLR_OVF (CLR_OVF)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; called at posedge+1, returns at the next posedge+1
  // after checking the state the edge produced.
  task automatic cycle(input bit vin, input logic [NB-1:0] din, input bit rd,
                       input bit clr);
    bit pop, push, drop;
    VIN = vin; DIN = din; RD = rd; CLR_OVF = clr;
    pop  = (m_count != 0) && rd;
    push = vin && ((m_count < DEPTH) || pop);
    drop = vin && !push;
    m_count = m_count + int'(push) - int'(pop);
    if (drop) begin
      m_ovf = 1;
      m_drops = clr ? 1 : ((m_drops == 255) ? 255 : m_drops + 1);
    end else if (clr) begin
      m_ovf = 0;
      m_drops = 0;
    end
    if (push) exp_q.push_back(din);
    @(posedge CLK); #1;
    VIN = 1'b0; RD = 1'b0; CLR_OVF = 1'b0;
    chk("count", int'(COUNT), m_count);
    chk("vout",  int'(VOUT),  int'(m_count != 0));
    chk("full",  int'(FULL),  int'(m_count == DEPTH));
    chk("ovf",   int'(OVF),   int'(m_ovf));
    chk("drops", int'(DROPS), m_drops);
  endtask

  // Monitor: a pop happens at the next rising edge when VOUT and RD are high.
  initial begin
    forever begin
      @(negedge CLK);
      if (RST_n && VOUT && RD) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL dout_unexpected: got 0x%0h expected no sample", DOUT);
        end else begin
          logic [NB-1:0] e;
          e = exp_q.pop_front();
          if (DOUT !== e) begin
            n_bad++;
            $display("FAIL dout: got 0x%0h expected 0x%0h at %0t", DOUT, e, $time);
          end
        end
      end
    end
  end

  initial begin
    // reset state
    #12;
    chk("rst_vout", int'(VOUT), 0);
    chk("rst_count", int'(COUNT), 0);
    chk("rst_dout", int'(DOUT), 0);
    chk("rst_full", int'(FULL), 0);
    RST_n = 1'b1;
    @(posedge CLK); #1;

    // three samples streamed through with the consumer always ready
    cycle(1, 12'h001, 1, 0);
    chk("lat_dout0", int'(DOUT), 12'h001);
    cycle(1, 12'h7FF, 1, 0);
    cycle(1, 12'h800, 1, 0);
    cycle(0, 12'h000, 1, 0);
    chk("drain_vout", int'(VOUT), 0);

    // fill with consumer stalled, then drain
    for (int i = 0; i < 8; i++) cycle(1, 12'h010 + 12'(i), 0, 0);
    chk("fill_full", int'(FULL), 1);
    chk("fill_count", int'(COUNT), 8);
    for (int i = 0; i < 8; i++) cycle(0, 12'h000, 1, 0);
    chk("drain_count", int'(COUNT), 0);

    // refill, overflow by three, then clear the status
    for (int i = 0; i < 8; i++) cycle(1, 12'h010 + 12'(i), 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 12'h0A0 + 12'(i), 0, 0);
    chk("ovf3_ovf", int'(OVF), 1);
    chk("ovf3_drops", int'(DROPS), 3);
    chk("ovf3_head", int'(DOUT), 12'h010);
    cycle(0, 12'h000, 0, 1);
    chk("clr_ovf", int'(OVF), 0);
    chk("clr_drops", int'(DROPS), 0);

    // full with simultaneous push and pop across pointer wrap
    for (int i = 0; i < 20; i++) cycle(1, 12'h100 + 12'(i), 1, 0);
    chk("stream_count", int'(COUNT), 8);
    chk("stream_drops", int'(DROPS), 0);

    // 300 drops saturate the counter
    for (int i = 0; i < 300; i++) cycle(1, 12'hBAD, 0, 0);
    chk("sat_drops", int'(DROPS), 255);
    chk("sat_ovf", int'(OVF), 1);
    cycle(1, 12'hBAD, 0, 1);
    chk("clrdrop_ovf", int'(OVF), 1);
    chk("clrdrop_drops", int'(DROPS), 1);

    // drain, then leave five samples and reset between edges
    for (int i = 0; i < 8; i++) cycle(0, 12'h000, 1, 0);
    for (int i = 0; i < 5; i++) cycle(1, 12'h200 + 12'(i), 0, 0);
    chk("pre_rst_count", int'(COUNT), 5);
    #2 RST_n = 1'b0;
    #1;
    chk("arst_vout", int'(VOUT), 0);
    chk("arst_count", int'(COUNT), 0);
    chk("arst_dout", int'(DOUT), 0);
    exp_q.delete();
    m_count = 0; m_ovf = 0; m_drops = 0;
    #1 RST_n = 1'b1;
    @(posedge CLK); #1;
    cycle(1, 12'h123, 0, 0);
    chk("post_rst_head", int'(DOUT), 12'h123);
    cycle(0, 12'h000, 1, 0);
    cycle(0, 12'h000, 0, 0);
    chk("end_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Safety net in case the stimulus stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule : tb_iir_out_buffer
